// File: rtl/lcd_spi_rx_if.sv
// Byte stream leaving lcd_spi_rx: FIFO head plus its tags, with a ready/valid handshake.
interface lcd_spi_rx_if #(
  parameter int IDX_W = 14
) ();
  logic             BYTE_VALID;
  logic             BYTE_READY;
  logic [7:0]       BYTE_DATA;
  logic             BYTE_DC;
  logic [7:0]       BYTE_CMD;
  logic [IDX_W-1:0] BYTE_IDX;

  modport master (
    output BYTE_VALID, BYTE_DATA, BYTE_DC, BYTE_CMD, BYTE_IDX,
    input  BYTE_READY
  );

  modport slave (
    input  BYTE_VALID, BYTE_DATA, BYTE_DC, BYTE_CMD, BYTE_IDX,
    output BYTE_READY
  );
endinterface

// File: rtl/lcd_spi_rx.sv
// Display-side receiver for the write-only 4-wire LCD SPI link: oversamples the bus,
// rebuilds bytes, tags them with command/parameter index and pairs 0x2C data into RGB565 pixels.
module lcd_spi_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4,
  parameter int IDX_W       = 14
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        SCL_IN,
  input  logic        MOSI_IN,
  input  logic        CS_IN,
  input  logic        DC_IN,
  input  logic        LCD_RST_IN,
  lcd_spi_rx_if.master byte_if,
  output logic        PIX_VALID,
  output logic [15:0] PIX_DATA,
  output logic        OVERFLOW,
  output logic        FRAME_ERR
);

  localparam int              PTR_W     = $clog2(FIFO_DEPTH);
  localparam logic [7:0]      CMD_RAMWR = 8'h2C;
  localparam logic [0:0]      PH_HI     = 1'b0;
  localparam logic [0:0]      PH_LO     = 1'b1;
  localparam logic [4:0]      SYNC_IDLE = 5'b10101;  // {scl, mosi, cs, dc, lcd_rst}
  localparam logic [PTR_W:0]  CNT_FULL  = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]  CNT_ONE   = (PTR_W + 1)'(1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  typedef struct packed {
    logic [7:0]       data;
    logic             dc;
    logic [7:0]       cmd;
    logic [IDX_W-1:0] idx;
  } entry_t;

  logic [SYNC_STAGES-1:0][4:0] sync_q;
  logic scl_s, mosi_s, cs_s, dc_s, lrst_s;
  logic scl_prev, cs_prev;
  logic [7:0] shreg;
  logic [2:0] bit_cnt;
  logic [7:0] cmd_q;
  logic [IDX_W-1:0] idx_q;
  logic [0:0] phase;
  logic [7:0] pix_hi;
  logic push_q;
  entry_t push_entry;

  assign {scl_s, mosi_s, cs_s, dc_s, lrst_s} = sync_q[SYNC_STAGES-1];

  logic scl_rise, cs_rise, shift_en, byte_done;
  logic [7:0] byte_next;
  entry_t new_entry;

  assign scl_rise  = scl_s & ~scl_prev;
  assign cs_rise   = cs_s & ~cs_prev;
  assign shift_en  = scl_rise & ~cs_s & lrst_s;
  assign byte_next = {shreg[6:0], mosi_s};
  assign byte_done = shift_en && (bit_cnt == 3'd7);

  // Command bytes tag themselves; data bytes carry the command and index in force.
  always_comb begin
    new_entry      = '0;
    new_entry.data = byte_next;
    new_entry.dc   = dc_s;
    new_entry.cmd  = dc_s ? cmd_q : byte_next;
    new_entry.idx  = dc_s ? idx_q : '0;
  end

  // Decoding happens on the cycle the 8th bit lands, so PIX_VALID coincides with push_q.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync_q     <= {SYNC_STAGES{SYNC_IDLE}};
      scl_prev   <= 1'b1;
      cs_prev    <= 1'b1;
      shreg      <= '0;
      bit_cnt    <= '0;
      cmd_q      <= '0;
      idx_q      <= '0;
      phase      <= PH_HI;
      pix_hi     <= '0;
      push_q     <= 1'b0;
      push_entry <= '0;
      PIX_VALID  <= 1'b0;
      PIX_DATA   <= '0;
      FRAME_ERR  <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], {SCL_IN, MOSI_IN, CS_IN, DC_IN, LCD_RST_IN}};
      scl_prev  <= scl_s;
      cs_prev   <= cs_s;
      push_q    <= 1'b0;
      PIX_VALID <= 1'b0;
      FRAME_ERR <= 1'b0;
      if (!lrst_s) begin
        bit_cnt <= '0;
        cmd_q   <= '0;
        idx_q   <= '0;
        phase   <= PH_HI;
      end else begin
        if (shift_en) begin
          shreg   <= byte_next;
          bit_cnt <= bit_cnt + 3'd1;
        end else if (cs_rise && bit_cnt != 3'd0) begin
          FRAME_ERR <= 1'b1;
          bit_cnt   <= '0;
        end
        if (byte_done) begin
          push_q     <= 1'b1;
          push_entry <= new_entry;
          if (!dc_s) begin
            cmd_q <= byte_next;
            idx_q <= '0;
            phase <= PH_HI;
          end else begin
            if (idx_q != '1) idx_q <= idx_q + IDX_ONE;
            if (cmd_q == CMD_RAMWR) begin
              if (phase == PH_HI) begin
                pix_hi <= byte_next;
                phase  <= PH_LO;
              end else begin
                PIX_DATA  <= {pix_hi, byte_next};
                PIX_VALID <= 1'b1;
                phase     <= PH_HI;
              end
            end
          end
        end
      end
    end
  end

  entry_t mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0] count;
  logic fifo_valid, full, pop, push_ok;
  entry_t head;

  assign fifo_valid = (count != '0);
  assign full       = (count == CNT_FULL);
  assign pop        = fifo_valid & byte_if.BYTE_READY;
  assign push_ok    = push_q & (~full | pop);
  assign head       = mem[rd_ptr];

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      OVERFLOW <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)     rd_ptr <= rd_ptr + PTR_ONE;
      case ({push_ok, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: ;
      endcase
      if (push_q && !push_ok) OVERFLOW <= 1'b1;
    end
  end

  // NOTE: storage is not reset; empty slots are never observable because outputs are gated by valid.
  always_ff @(posedge CLK) begin
    if (push_ok) mem[wr_ptr] <= push_entry;
  end

  assign byte_if.BYTE_VALID = fifo_valid;
  assign byte_if.BYTE_DATA  = fifo_valid ? head.data : '0;
  assign byte_if.BYTE_DC    = fifo_valid ? head.dc   : 1'b0;
  assign byte_if.BYTE_CMD   = fifo_valid ? head.cmd  : '0;
  assign byte_if.BYTE_IDX   = fifo_valid ? head.idx  : '0;

endmodule
